// File: rtl/pong_motion_if.sv
// Bundle between the sync generator / controls and the pong game-state engine.
// With SCORE_EN defined the bundle also carries the 8-bit hit score.
interface pong_motion_if;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [1:0] btn;
    logic       serve;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] paddle_x;
    logic [9:0] paddle_y;
    logic       hit;
    logic       miss;
`ifdef SCORE_EN
    logic [7:0] score;
`endif

    modport master (
        output pix_x, pix_y, btn, serve,
`ifdef SCORE_EN
        input  score,
`endif
        input  ball_x, ball_y, paddle_x, paddle_y, hit, miss
    );

    modport slave (
        input  pix_x, pix_y, btn, serve,
`ifdef SCORE_EN
        output score,
`endif
        output ball_x, ball_y, paddle_x, paddle_y, hit, miss
    );
endinterface

// File: rtl/pong_motion.sv
// Pong game-state engine: ball/paddle motion, bounces and serve/miss FSM, one step per frame.
// Define SCORE_EN to add a saturating 8-bit hit counter on bus.score.
module pong_motion #(
    parameter int unsigned PADDLE_X    = 600,
    parameter int unsigned PADDLE_V    = 4,
    parameter int unsigned BALL_V      = 2,
    parameter int unsigned MISS_FRAMES = 60
) (
    input  logic         clk,
    input  logic         reset,
    pong_motion_if.slave bus
);
    localparam int unsigned PW = 10;
    localparam int unsigned AW = 11;
    localparam int unsigned CW = $clog2(MISS_FRAMES + 1);
`ifdef SCORE_EN
    localparam int unsigned SW = 8;
`endif

    localparam logic [PW-1:0] HOME_X    = PW'(312);
    localparam logic [PW-1:0] HOME_Y    = PW'(232);
    localparam logic [PW-1:0] PAD_HOME  = PW'(208);
    localparam logic [PW-1:0] TICK_ROW  = PW'(481);
    localparam logic [AW-1:0] BALL_SIZE = AW'(16);
    localparam logic [AW-1:0] PAD_W     = AW'(16);
    localparam logic [AW-1:0] PAD_H     = AW'(64);
    localparam logic [AW-1:0] WALL_TOP  = AW'(16);
    localparam logic [AW-1:0] WALL_BOT  = AW'(464);
    localparam logic [AW-1:0] WALL_LEFT = AW'(16);
    localparam logic [AW-1:0] EXIT_X    = AW'(624);
    localparam logic [AW-1:0] PAD_MIN   = AW'(16);
    localparam logic [AW-1:0] PAD_MAX   = AW'(400);
    localparam logic [AW-1:0] PAD_L     = AW'(PADDLE_X);
    localparam logic [AW-1:0] PAD_STEP  = AW'(PADDLE_V);
    localparam logic [AW-1:0] BALL_STEP = AW'(BALL_V);
    localparam logic [CW-1:0] MISS_LAST = CW'(MISS_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_MISS
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] ball_x, ball_x_n;
    logic [PW-1:0] ball_y, ball_y_n;
    logic [PW-1:0] paddle_y, paddle_y_n;
    logic          dx_neg, dx_neg_n;
    logic          dy_neg, dy_neg_n;
    logic          hit, hit_n;
    logic          miss, miss_n;
    logic [CW-1:0] miss_cnt, miss_cnt_n;
    logic          row_q;
`ifdef SCORE_EN
    logic [SW-1:0] score, score_n;
`endif

    logic          row_c;
    logic          tick_c;
    logic          hit_c;
    logic          dx_c;
    logic          dy_c;
    logic [AW-1:0] bx_w;
    logic [AW-1:0] by_w;
    logic [AW-1:0] py_w;
    logic [AW-1:0] paddle_mv_c;

    // One tick per frame, however long pix_x dwells at column 0 of row 481.
    assign row_c  = (bus.pix_y == TICK_ROW) && (bus.pix_x == '0);
    assign tick_c = row_c && !row_q;

    assign bx_w = AW'(ball_x);
    assign by_w = AW'(ball_y);
    assign py_w = AW'(paddle_y);

    assign hit_c = (state == S_PLAY) && !dx_neg
                && (bx_w + BALL_SIZE >= PAD_L)
                && (bx_w + BALL_SIZE <= PAD_L + PAD_W)
                && (by_w + BALL_SIZE > py_w)
                && (by_w < py_w + PAD_H);

    function automatic logic [PW-1:0] step(input logic [AW-1:0] pos, input logic neg);
        return neg ? PW'(pos - BALL_STEP) : PW'(pos + BALL_STEP);
    endfunction

    // Clamped paddle position for the current button state.
    always_comb begin
        paddle_mv_c = py_w;
        case (bus.btn)
            2'b01:   paddle_mv_c = (py_w + PAD_STEP > PAD_MAX) ? PAD_MAX : py_w + PAD_STEP;
            2'b10:   paddle_mv_c = (py_w < PAD_MIN + PAD_STEP) ? PAD_MIN : py_w - PAD_STEP;
            default: paddle_mv_c = py_w;
        endcase
    end

    always_comb begin
        state_n    = state;
        ball_x_n   = ball_x;
        ball_y_n   = ball_y;
        paddle_y_n = paddle_y;
        dx_neg_n   = dx_neg;
        dy_neg_n   = dy_neg;
        miss_cnt_n = miss_cnt;
        hit_n      = 1'b0;
        miss_n     = 1'b0;
        dx_c       = dx_neg;
        dy_c       = dy_neg;
`ifdef SCORE_EN
        score_n    = score;
`endif
        if (tick_c) begin
            if (state != S_MISS) begin
                paddle_y_n = PW'(paddle_mv_c);
            end
            case (state)
                S_IDLE: begin
                    ball_x_n = HOME_X;
                    ball_y_n = HOME_Y;
                    if (bus.serve) begin
                        state_n  = S_PLAY;
                        dx_neg_n = 1'b0;
                        dy_neg_n = 1'b0;
                    end
                end
                S_PLAY: begin
                    // Velocity from the current position first; checks are independent.
                    if (by_w <= WALL_TOP)              dy_c = 1'b0;
                    if (by_w + BALL_SIZE >= WALL_BOT)  dy_c = 1'b1;
                    if (bx_w <= WALL_LEFT)             dx_c = 1'b0;
                    if (hit_c)                         dx_c = 1'b1;
                    if (bx_w >= EXIT_X && !hit_c) begin
                        state_n    = S_MISS;
                        miss_n     = 1'b1;
                        miss_cnt_n = '0;
                    end else begin
                        dx_neg_n = dx_c;
                        dy_neg_n = dy_c;
                        ball_x_n = step(bx_w, dx_c);
                        ball_y_n = step(by_w, dy_c);
                        hit_n    = hit_c;
`ifdef SCORE_EN
                        if (hit_c && score != '1) score_n = score + SW'(1);
`endif
                    end
                end
                S_MISS: begin
                    if (miss_cnt == MISS_LAST) begin
                        state_n    = S_IDLE;
                        miss_cnt_n = '0;
                        ball_x_n   = HOME_X;
                        ball_y_n   = HOME_Y;
                        dx_neg_n   = 1'b0;
                        dy_neg_n   = 1'b0;
`ifdef SCORE_EN
                        score_n    = '0;
`endif
                    end else begin
                        miss_cnt_n = miss_cnt + CW'(1);
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            ball_x   <= HOME_X;
            ball_y   <= HOME_Y;
            paddle_y <= PAD_HOME;
            dx_neg   <= 1'b0;
            dy_neg   <= 1'b0;
            hit      <= 1'b0;
            miss     <= 1'b0;
            miss_cnt <= '0;
            row_q    <= 1'b0;
        end else begin
            state    <= state_n;
            ball_x   <= ball_x_n;
            ball_y   <= ball_y_n;
            paddle_y <= paddle_y_n;
            dx_neg   <= dx_neg_n;
            dy_neg   <= dy_neg_n;
            hit      <= hit_n;
            miss     <= miss_n;
            miss_cnt <= miss_cnt_n;
            row_q    <= row_c;
        end
    end

`ifdef SCORE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score <= '0;
        end else begin
            score <= score_n;
        end
    end

    assign bus.score = score;
`endif

    assign bus.ball_x   = ball_x;
    assign bus.ball_y   = ball_y;
    assign bus.paddle_x = PW'(PADDLE_X);
    assign bus.paddle_y = paddle_y;
    assign bus.hit      = hit;
    assign bus.miss     = miss;
endmodule

// File: tb/tb_pong_motion.sv
// Self-checking bench for pong_motion: compressed frame scans, a per-frame reference model
// feeding a scoreboard queue, plus directed checks on walls, paddle hit, miss and reset.
module tb_pong_motion;
    localparam int HOME_X = 312;
    localparam int HOME_Y = 232;
    localparam int PAD_X  = 600;
    localparam int PAD_V  = 4;
    localparam int BV     = 2;
    localparam int MISS_N = 60;

    typedef struct {
        int bx;
        int by;
        int py;
        int hit;
        int miss;
        int score;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pong_motion_if bus ();

    pong_motion dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_tick = 1'b0;
    logic last_hit = 1'b0;
    logic last_miss = 1'b0;

    // Reference game state: 0 idle, 1 play, 2 miss
    int m_state, m_bx, m_by, m_vx, m_vy, m_py, m_cnt, m_score;

    task automatic model_reset;
        m_state = 0; m_bx = HOME_X; m_by = HOME_Y; m_vx = BV; m_vy = BV;
        m_py = 208; m_cnt = 0; m_score = 0;
    endtask

    task automatic model_step(input logic [1:0] b, input logic s);
        exp_t e;
        int nvx, nvy, was, h, m;
        h = 0; m = 0; was = m_state;
        case (m_state)
            0: if (s) begin m_state = 1; m_vx = BV; m_vy = BV; end
            1: begin
                nvx = m_vx; nvy = m_vy;
                if (m_by <= 16) nvy = BV;
                if (m_by + 16 >= 464) nvy = -BV;
                if (m_bx <= 16) nvx = BV;
                if (m_vx > 0 && m_bx + 16 >= PAD_X && m_bx + 16 <= PAD_X + 16 &&
                    m_by + 16 > m_py && m_by < m_py + 64) begin
                    nvx = -BV; h = 1;
                end
                if (m_bx >= 624 && h == 0) begin
                    m = 1; m_state = 2; m_cnt = 0;
                end else begin
                    m_vx = nvx; m_vy = nvy; m_bx = m_bx + nvx; m_by = m_by + nvy;
                    if (h == 1 && m_score < 255) m_score++;
                end
            end
            default: begin
                if (m_cnt == MISS_N - 1) begin
                    m_state = 0; m_cnt = 0; m_bx = HOME_X; m_by = HOME_Y; m_score = 0;
                end else begin
                    m_cnt++;
                end
            end
        endcase
        if (was != 2) begin
            if (b == 2'b01) m_py = (m_py + PAD_V > 400) ? 400 : m_py + PAD_V;
            else if (b == 2'b10) m_py = (m_py - PAD_V < 16) ? 16 : m_py - PAD_V;
        end
        e.bx = m_bx; e.by = m_by; e.py = m_py; e.hit = h; e.miss = m; e.score = m_score;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: pops one expected frame result after each tick edge.
    always @(posedge clk) begin
        if (exp_tick) begin
            #1;
            if (sb_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL sb_empty: no expected entry at t=%0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                last_hit  = bus.hit;
                last_miss = bus.miss;
                n_checks++;
                if (bus.ball_x !== 10'(mon_e.bx)) begin n_fail++; $display("FAIL sb_ball_x: got %0d, expected %0d", bus.ball_x, mon_e.bx); end
                n_checks++;
                if (bus.ball_y !== 10'(mon_e.by)) begin n_fail++; $display("FAIL sb_ball_y: got %0d, expected %0d", bus.ball_y, mon_e.by); end
                n_checks++;
                if (bus.paddle_y !== 10'(mon_e.py)) begin n_fail++; $display("FAIL sb_paddle_y: got %0d, expected %0d", bus.paddle_y, mon_e.py); end
                n_checks++;
                if (bus.hit !== 1'(mon_e.hit)) begin n_fail++; $display("FAIL sb_hit: got %0b, expected %0d", bus.hit, mon_e.hit); end
                n_checks++;
                if (bus.miss !== 1'(mon_e.miss)) begin n_fail++; $display("FAIL sb_miss: got %0b, expected %0d", bus.miss, mon_e.miss); end
`ifdef SCORE_EN
                n_checks++;
                if (bus.score !== 8'(mon_e.score)) begin n_fail++; $display("FAIL sb_score: got %0d, expected %0d", bus.score, mon_e.score); end
`endif
            end
        end
    end

    // One compressed frame: row 480, then (0,481) held two clocks, then column 1.
    task automatic run_frame(input logic [1:0] b, input logic s);
        @(negedge clk);
        bus.pix_y = 10'd480; bus.pix_x = 10'd5; bus.btn = b; bus.serve = s;
        @(negedge clk);
        bus.pix_y = 10'd481; bus.pix_x = 10'd0;
        model_step(b, s);
        exp_tick = 1'b1;
        @(posedge clk); #2;
        exp_tick = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.hit !== 1'b0 || bus.miss !== 1'b0 || bus.ball_x !== 10'(m_bx) ||
            bus.ball_y !== 10'(m_by) || bus.paddle_y !== 10'(m_py)) begin
            n_fail++;
            $display("FAIL hold_second_clock: hit=%0b miss=%0b ball=(%0d,%0d) pad=%0d, expected 0 0 (%0d,%0d) %0d",
                     bus.hit, bus.miss, bus.ball_x, bus.ball_y, bus.paddle_y, m_bx, m_by, m_py);
        end
        @(negedge clk);
        bus.pix_x = 10'd1;
    endtask

    task automatic test_reset;
        bus.pix_x = 10'd0; bus.pix_y = 10'd0; bus.btn = 2'b00; bus.serve = 1'b0;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.ball_x !== 10'd312) begin n_fail++; $display("FAIL reset_ball_x: got %0d, expected 312", bus.ball_x); end
        n_checks++; if (bus.ball_y !== 10'd232) begin n_fail++; $display("FAIL reset_ball_y: got %0d, expected 232", bus.ball_y); end
        n_checks++; if (bus.paddle_x !== 10'd600) begin n_fail++; $display("FAIL reset_paddle_x: got %0d, expected 600", bus.paddle_x); end
        n_checks++; if (bus.paddle_y !== 10'd208) begin n_fail++; $display("FAIL reset_paddle_y: got %0d, expected 208", bus.paddle_y); end
        n_checks++; if (bus.hit !== 1'b0 || bus.miss !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: hit=%0b miss=%0b, expected 0 0", bus.hit, bus.miss); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_frame_tick;
        // Near-miss scan positions must not tick.
        @(negedge clk);
        bus.btn = 2'b01; bus.pix_y = 10'd481; bus.pix_x = 10'd3;
        @(negedge clk); bus.pix_y = 10'd480; bus.pix_x = 10'd0;
        @(negedge clk); bus.pix_y = 10'd482; bus.pix_x = 10'd0;
        @(negedge clk); #1;
        n_checks++; if (bus.paddle_y !== 10'd208) begin n_fail++; $display("FAIL no_tick_decode: paddle_y=%0d, expected 208", bus.paddle_y); end
        bus.btn = 2'b00;
        run_frame(2'b00, 1'b0);
        n_checks++;
        if (bus.ball_x !== 10'd312 || bus.ball_y !== 10'd232 || bus.paddle_y !== 10'd208) begin
            n_fail++; $display("FAIL idle_frame: ball=(%0d,%0d) pad=%0d, expected (312,232) 208", bus.ball_x, bus.ball_y, bus.paddle_y);
        end
    endtask

    task automatic test_paddle;
        run_frame(2'b01, 1'b0);
        n_checks++; if (bus.paddle_y !== 10'd212) begin n_fail++; $display("FAIL paddle_first_step: got %0d, expected 212", bus.paddle_y); end
        repeat (59) run_frame(2'b01, 1'b0);
        n_checks++; if (bus.paddle_y !== 10'd400) begin n_fail++; $display("FAIL paddle_clamp_400: got %0d, expected 400", bus.paddle_y); end
        repeat (100) run_frame(2'b10, 1'b0);
        n_checks++; if (bus.paddle_y !== 10'd16) begin n_fail++; $display("FAIL paddle_clamp_16: got %0d, expected 16", bus.paddle_y); end
        repeat (5) run_frame(2'b11, 1'b0);
        n_checks++; if (bus.paddle_y !== 10'd16) begin n_fail++; $display("FAIL paddle_btn_11: got %0d, expected 16", bus.paddle_y); end
        repeat (96) run_frame(2'b01, 1'b0);
        n_checks++; if (bus.paddle_y !== 10'd400) begin n_fail++; $display("FAIL paddle_return_400: got %0d, expected 400", bus.paddle_y); end
    endtask

    task automatic test_serve;
        run_frame(2'b00, 1'b1);
        n_checks++; if (bus.ball_x !== 10'd312 || bus.ball_y !== 10'd232) begin n_fail++; $display("FAIL serve_tick: ball=(%0d,%0d), expected (312,232)", bus.ball_x, bus.ball_y); end
        run_frame(2'b00, 1'b0);
        n_checks++; if (bus.ball_x !== 10'd314 || bus.ball_y !== 10'd234) begin n_fail++; $display("FAIL serve_step1: ball=(%0d,%0d), expected (314,234)", bus.ball_x, bus.ball_y); end
        run_frame(2'b00, 1'b1);
        n_checks++; if (bus.ball_x !== 10'd316 || bus.ball_y !== 10'd236) begin n_fail++; $display("FAIL serve_step2: ball=(%0d,%0d), expected (316,236)", bus.ball_x, bus.ball_y); end
    endtask

    task automatic test_bottom_wall;
        int n;
        n = 0;
        while (bus.ball_y != 10'd448 && n < 200) begin run_frame(2'b00, 1'b0); n++; end
        n_checks++; if (bus.ball_y !== 10'd448) begin n_fail++; $display("FAIL bottom_reach: ball_y=%0d, expected 448 within 200 frames", bus.ball_y); end
        run_frame(2'b00, 1'b0);
        n_checks++; if (bus.ball_y !== 10'd446) begin n_fail++; $display("FAIL bottom_bounce: ball_y=%0d, expected 446", bus.ball_y); end
    endtask

    task automatic test_paddle_hit;
        int n;
        n = 0;
        while (bus.ball_x != 10'd584 && n < 200) begin run_frame(2'b00, 1'b0); n++; end
        n_checks++; if (bus.ball_x !== 10'd584) begin n_fail++; $display("FAIL hit_reach: ball_x=%0d, expected 584 within 200 frames", bus.ball_x); end
        run_frame(2'b00, 1'b0);
        n_checks++; if (last_hit !== 1'b1) begin n_fail++; $display("FAIL hit_pulse: hit=%0b, expected 1", last_hit); end
        n_checks++; if (bus.ball_x !== 10'd582) begin n_fail++; $display("FAIL hit_rebound: ball_x=%0d, expected 582", bus.ball_x); end
`ifdef SCORE_EN
        n_checks++; if (bus.score !== 8'd1) begin n_fail++; $display("FAIL hit_score: score=%0d, expected 1", bus.score); end
`endif
    endtask

    task automatic test_left_wall;
        int n;
        n = 0;
        while (bus.ball_x != 10'd16 && n < 400) begin run_frame(2'b00, 1'b0); n++; end
        n_checks++; if (bus.ball_x !== 10'd16) begin n_fail++; $display("FAIL left_reach: ball_x=%0d, expected 16 within 400 frames", bus.ball_x); end
        run_frame(2'b00, 1'b0);
        n_checks++; if (bus.ball_x !== 10'd18) begin n_fail++; $display("FAIL left_bounce: ball_x=%0d, expected 18", bus.ball_x); end
    endtask

    task automatic miss_and_recover(input logic [1:0] b);
        int n;
        int pad;
        n = 0;
        last_miss = 1'b0;
        while (last_miss != 1'b1 && n < 500) begin run_frame(b, 1'b0); n++; end
        n_checks++; if (last_miss !== 1'b1) begin n_fail++; $display("FAIL miss_pulse: no miss within 500 frames"); end
        n_checks++; if (bus.ball_x !== 10'd624) begin n_fail++; $display("FAIL miss_pos: ball_x=%0d, expected 624", bus.ball_x); end
        pad = int'(bus.paddle_y);
        repeat (MISS_N - 1) run_frame(2'b01, 1'b0);
        n_checks++; if (bus.ball_x !== 10'd624 || bus.paddle_y !== 10'(pad)) begin n_fail++; $display("FAIL miss_frozen: ball_x=%0d pad=%0d, expected 624 %0d", bus.ball_x, bus.paddle_y, pad); end
        run_frame(2'b01, 1'b0);
        n_checks++; if (bus.ball_x !== 10'd312 || bus.ball_y !== 10'd232) begin n_fail++; $display("FAIL miss_to_idle: ball=(%0d,%0d), expected (312,232)", bus.ball_x, bus.ball_y); end
`ifdef SCORE_EN
        n_checks++; if (bus.score !== 8'd0) begin n_fail++; $display("FAIL miss_score_clear: score=%0d, expected 0", bus.score); end
`endif
    endtask

    task automatic test_miss;
        miss_and_recover(2'b10);
    endtask

    task automatic test_reset_in_miss;
        int n;
        run_frame(2'b00, 1'b1);
        n = 0;
        last_miss = 1'b0;
        while (last_miss != 1'b1 && n < 300) begin run_frame(2'b00, 1'b0); n++; end
        n_checks++; if (last_miss !== 1'b1) begin n_fail++; $display("FAIL rim_miss: no miss within 300 frames"); end
        repeat (10) run_frame(2'b00, 1'b0);
        @(negedge clk);
        bus.pix_y = 10'd481; bus.pix_x = 10'd0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.ball_x !== 10'd312 || bus.ball_y !== 10'd232 || bus.paddle_y !== 10'd208 ||
            bus.hit !== 1'b0 || bus.miss !== 1'b0) begin
            n_fail++; $display("FAIL rim_async: ball=(%0d,%0d) pad=%0d hit=%0b miss=%0b, expected (312,232) 208 0 0",
                               bus.ball_x, bus.ball_y, bus.paddle_y, bus.hit, bus.miss);
        end
`ifdef SCORE_EN
        n_checks++; if (bus.score !== 8'd0) begin n_fail++; $display("FAIL rim_score: score=%0d, expected 0", bus.score); end
`endif
        @(negedge clk);
        bus.pix_y = 10'd0; bus.pix_x = 10'd1;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) run_frame(2'b00, 1'b0);
        n_checks++; if (bus.ball_x !== 10'd312) begin n_fail++; $display("FAIL rim_idle: ball_x=%0d, expected 312", bus.ball_x); end
        run_frame(2'b00, 1'b1);
        run_frame(2'b00, 1'b0);
        n_checks++; if (bus.ball_x !== 10'd314 || bus.ball_y !== 10'd234) begin n_fail++; $display("FAIL rim_serve: ball=(%0d,%0d), expected (314,234)", bus.ball_x, bus.ball_y); end
        miss_and_recover(2'b00);
    endtask

    initial begin
        test_reset();
        test_frame_tick();
        test_paddle();
        test_serve();
        test_bottom_wall();
        test_paddle_hit();
        test_left_wall();
        test_miss();
        test_reset_in_miss();
        n_checks++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: %0d entries, expected 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end
endmodule
